cla_pipe: RTL and testbench

- Parametrised WIDTH-bit carry-lookahead adder, two pipeline stages, valid/ready handshake on input and output.
- Built from GROUP-bit lookahead cells with a second-level carry-lookahead across groups.
- Datapath arithmetic primitive for the ALU/sum board; sustains one operation per clock under no backpressure.

---
 rtl/cla_pipe_pkg.sv | 49 ++++
 rtl/cla_pipe_group.sv | 33 +++
 rtl/cla_pipe.sv | 182 ++++++++++++++++++
 tb/tb_cla_pipe.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pipe_pkg.sv
// Shared types, group-count helper and prefix-carry function for the cla_pipe adder.
// Also defines the elaboration guard macro CLA_ASSERT_GROUPS.
`ifndef CLA_PIPE_PKG_SV
`define CLA_PIPE_PKG_SV

// Expands to a generate-time check that W splits evenly into G-bit groups.
`define CLA_ASSERT_GROUPS(W, G) \
    if (((W) % (G)) != 0) begin : g_width_check \
        $error("cla_pipe: WIDTH must be a multiple of GROUP"); \
    end

package cla_pkg;

    localparam int unsigned MAX_SPAN = 64;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int unsigned num_groups(input int unsigned width,
                                               input int unsigned group);
        return width / group;
    endfunction

    // Flat sum-of-products carry into position n (no ripple chain).
    function automatic logic carry_into(input logic [MAX_SPAN-1:0] g,
                                        input logic [MAX_SPAN-1:0] p,
                                        input logic                cin,
                                        input int unsigned         n);
        logic c;
        logic t;
        c = cin;
        for (int unsigned j = 0; j < n; j++) begin
            c = c & p[j];
        end
        for (int unsigned j = 0; j < n; j++) begin
            t = g[j];
            for (int unsigned k = j + 1; k < n; k++) begin
                t = t & p[k];
            end
            c = c | t;
        end
        return c;
    endfunction

endpackage

`endif

// File: rtl/cla_pipe_group.sv
// Combinational GROUP-bit carry-lookahead cell: group G/P, in-group carries and sum bits.
module cla_group
    import cla_pkg::*;
#(
    parameter int unsigned GROUP = 4
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             cin,
    output logic             gg,
    output logic             gp,
    output logic [GROUP-1:0] c,
    output logic [GROUP-1:0] sum
);

    logic [MAX_SPAN-1:0] p_x;
    logic [MAX_SPAN-1:0] g_x;

    always_comb begin
        p_x            = '0;
        g_x            = '0;
        p_x[GROUP-1:0] = p;
        g_x[GROUP-1:0] = g;
        c              = '0;
        for (int unsigned i = 0; i < GROUP; i++) begin
            c[i] = carry_into(g_x, p_x, cin, i);
        end
        gg  = carry_into(g_x, p_x, 1'b0, GROUP);
        gp  = &p;
        sum = p ^ c;
    end

endmodule

// File: rtl/cla_pipe.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake on both sides.
// Optional macro CLA_PIPE_SUB_EN adds a 'sub' input selecting s = a - b.
module cla_pipe
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef CLA_PIPE_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned NG = num_groups(WIDTH, GROUP);

    `CLA_ASSERT_GROUPS(WIDTH, GROUP)

    logic             adv1;
    logic             adv2;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;
    logic [NG-1:0]    grp_g_in;
    logic [NG-1:0]    grp_p_in;
    logic [WIDTH-1:0] unused_s1_c;
    logic [WIDTH-1:0] unused_s1_sum;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_p_q, s1_p_d;
    logic [WIDTH-1:0] s1_g_q, s1_g_d;
    gp_t  [NG-1:0]    s1_grp_q, s1_grp_d;
    logic             s1_cin_q, s1_cin_d;

    logic [MAX_SPAN-1:0] grp_g_x;
    logic [MAX_SPAN-1:0] grp_p_x;
    logic [NG:0]         grp_c;
    logic [WIDTH-1:0]    bit_c;
    logic [WIDTH-1:0]    sum_w;
    logic [NG-1:0]       unused_s2_gg;
    logic [NG-1:0]       unused_s2_gp;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_s_q, s2_s_d;
    logic             s2_cout_q, s2_cout_d;
    logic             s2_ovf_q, s2_ovf_d;

    always_comb begin
        adv2 = !s2_valid_q || out_ready;
        adv1 = !s1_valid_q || adv2;
    end

    assign in_ready = adv1;

    always_comb begin
`ifdef CLA_PIPE_SUB_EN
        b_eff   = sub ? ~b : b;
        cin_eff = sub ? 1'b1 : c_in;
`else
        b_eff   = b;
        cin_eff = c_in;
`endif
        p_in = a ^ b_eff;
        g_in = a & b_eff;
    end

    // Stage 1 only needs the group G/P outputs; carries here assume cin=0 and are discarded.
    for (genvar k = 0; k < NG; k++) begin : g_s1_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .p   (p_in[k*GROUP +: GROUP]),
            .g   (g_in[k*GROUP +: GROUP]),
            .cin (1'b0),
            .gg  (grp_g_in[k]),
            .gp  (grp_p_in[k]),
            .c   (unused_s1_c[k*GROUP +: GROUP]),
            .sum (unused_s1_sum[k*GROUP +: GROUP])
        );
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_p_d     = s1_p_q;
        s1_g_d     = s1_g_q;
        s1_grp_d   = s1_grp_q;
        s1_cin_d   = s1_cin_q;
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_p_d   = p_in;
                s1_g_d   = g_in;
                s1_cin_d = cin_eff;
                for (int unsigned k = 0; k < NG; k++) begin
                    s1_grp_d[k].g = grp_g_in[k];
                    s1_grp_d[k].p = grp_p_in[k];
                end
            end
        end
    end

    // Second-level lookahead: carry into every group, plus grp_c[NG] as the final carry out.
    always_comb begin
        grp_g_x = '0;
        grp_p_x = '0;
        for (int unsigned k = 0; k < NG; k++) begin
            grp_g_x[k] = s1_grp_q[k].g;
            grp_p_x[k] = s1_grp_q[k].p;
        end
        grp_c = '0;
        for (int unsigned k = 0; k <= NG; k++) begin
            grp_c[k] = carry_into(grp_g_x, grp_p_x, s1_cin_q, k);
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_s2_grp
        cla_group #(.GROUP(GROUP)) u_grp (
            .p   (s1_p_q[k*GROUP +: GROUP]),
            .g   (s1_g_q[k*GROUP +: GROUP]),
            .cin (grp_c[k]),
            .gg  (unused_s2_gg[k]),
            .gp  (unused_s2_gp[k]),
            .c   (bit_c[k*GROUP +: GROUP]),
            .sum (sum_w[k*GROUP +: GROUP])
        );
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_s_d     = s2_s_q;
        s2_cout_d  = s2_cout_q;
        s2_ovf_d   = s2_ovf_q;
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_s_d    = sum_w;
                s2_cout_d = grp_c[NG];
                s2_ovf_d  = bit_c[WIDTH-1] ^ grp_c[NG];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_p_q     <= '0;
            s1_g_q     <= '0;
            s1_grp_q   <= '0;
            s1_cin_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_s_q     <= '0;
            s2_cout_q  <= 1'b0;
            s2_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_p_q     <= s1_p_d;
            s1_g_q     <= s1_g_d;
            s1_grp_q   <= s1_grp_d;
            s1_cin_q   <= s1_cin_d;
            s2_valid_q <= s2_valid_d;
            s2_s_q     <= s2_s_d;
            s2_cout_q  <= s2_cout_d;
            s2_ovf_q   <= s2_ovf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign s         = s2_s_q;
    assign c_out     = s2_cout_q;
    assign ovf       = s2_ovf_q;

endmodule

// File: tb/tb_cla_pipe.sv
// Directed, table-driven bench for cla_pipe at WIDTH=16, GROUP=4.
// Define CLA_PIPE_SUB_EN for both RTL and bench to also exercise subtraction.
module tb_cla_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
`ifdef CLA_PIPE_SUB_EN
    logic        sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        c_out;
    logic        ovf;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    localparam int unsigned NV = 12;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    cla_pipe #(.WIDTH(16), .GROUP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef CLA_PIPE_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Streams the vector table through the DUT; entered and left at posedge+1.
    task automatic run_table(input bit random_mode);
        int unsigned idx;
        int unsigned q[$];
        int unsigned h;
        bit          held;
        logic [15:0] h_s;
        logic        h_co;
        logic        h_ov;
        idx  = 0;
        held = 1'b0;
        h_s  = '0;
        h_co = 1'b0;
        h_ov = 1'b0;
        for (int unsigned cyc = 0; cyc < 400 && (idx < NV || q.size() != 0); cyc++) begin
            if (idx < NV) begin
                in_valid = random_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                a        = vecs[idx].a;
                b        = vecs[idx].b;
                c_in     = vecs[idx].cin;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = random_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (held) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", {14'd0, ovf, c_out, s}, {14'd0, h_ov, h_co, h_s});
            end
            held = out_valid && !out_ready;
            h_s  = s;
            h_co = c_out;
            h_ov = ovf;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    h = q.pop_front();
                    check($sformatf("vec%0d_s", h), 32'(s), 32'(vecs[h].s));
                    check($sformatf("vec%0d_c_out", h), 32'(c_out), 32'(vecs[h].co));
                    check($sformatf("vec%0d_ovf", h), 32'(ovf), 32'(vecs[h].ov));
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(idx);
                idx++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("table_drained", (idx == NV && q.size() == 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // One beat through an idle pipeline; entered and left at posedge+1.
    task automatic single(input logic [15:0] ta, input logic [15:0] tb_val, input logic tc,
                          output logic [15:0] rs, output logic rco, output logic rov, output bit got);
        a         = ta;
        b         = tb_val;
        c_in      = tc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        got = 1'b0;
        rs  = '0;
        rco = 1'b0;
        rov = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                rs  = s;
                rco = c_out;
                rov = ovf;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rs;
        logic        rco;
        logic        rov;
        bit          got;

        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2]  = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[3]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[7]  = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[8]  = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[9]  = '{16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[11] = '{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = 16'h1234;
        b         = 16'h1111;
        c_in      = 1'b1;
`ifdef CLA_PIPE_SUB_EN
        sub       = 1'b0;
`endif

        // Reset held with in_valid asserted: nothing may emerge.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'(s), 32'h0000);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Latency: accepted at edge k, result sampled at edge k+2.
        a = 16'hFFFF; b = 16'h0001; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("lat_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("lat_k1_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_k2_valid", 32'(out_valid), 32'd1);
        check("lat_k2_s", 32'(s), 32'h0000);
        check("lat_k2_c_out", 32'(c_out), 32'd1);
        check("lat_k2_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_once", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        run_table(1'b0);
        run_table(1'b1);

        // Backpressure: two beats fill the pipe, third is refused until release.
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; c_in = 1'b0;
        a = 16'h0001; b = 16'h0001;
        @(negedge clk);
        check("bp_ready_c1", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 a = 16'h0002; b = 16'h0002;
        @(negedge clk);
        check("bp_ready_c2", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 a = 16'h0003; b = 16'h0003;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("bp_stall%0d_in_ready", i), 32'(in_ready), 32'd0);
            check($sformatf("bp_stall%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_stall%0d_s", i), 32'(s), 32'h0002);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_out0_valid", 32'(out_valid), 32'd1);
        check("bp_out0_s", 32'(s), 32'h0002);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_out1_valid", 32'(out_valid), 32'd1);
        check("bp_out1_s", 32'(s), 32'h0004);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_out2_valid", 32'(out_valid), 32'd1);
        check("bp_out2_s", 32'(s), 32'h0006);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_no_dup", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset pulse right after accepting a beat discards it.
        do_reset();
        a = 16'hAAAA; b = 16'h5555; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("rmid_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rmid_discard%0d", i), 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        single(16'h0010, 16'h0020, 1'b0, rs, rco, rov, got);
        check("rmid_next_seen", 32'(got), 32'd1);
        check("rmid_next_s", 32'(rs), 32'h0030);
        check("rmid_next_c_out", 32'(rco), 32'd0);
        @(negedge clk);
        check("rmid_next_once", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

`ifdef CLA_PIPE_SUB_EN
        sub = 1'b1;
        single(16'h0005, 16'h0007, 1'b0, rs, rco, rov, got);
        check("sub0_seen", 32'(got), 32'd1);
        check("sub0_s", 32'(rs), 32'hFFFE);
        check("sub0_c_out", 32'(rco), 32'd0);
        check("sub0_ovf", 32'(rov), 32'd0);
        single(16'h8000, 16'h0001, 1'b0, rs, rco, rov, got);
        check("sub1_seen", 32'(got), 32'd1);
        check("sub1_s", 32'(rs), 32'h7FFF);
        check("sub1_c_out", 32'(rco), 32'd1);
        check("sub1_ovf", 32'(rov), 32'd1);
        sub = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
